// File: rtl/p405s_wd_timer_event.sv
// p405s_wd_timer_event
// Watchdog / FIT timer event generator. Selects one time-base tap per timer,
// detects 0->1 transitions of the selected tap, and turns them into one-cycle
// status pulses. A watchdog event that finds ENW=WIS=1 raises a reset request
// to the reset logic through a small IDLE/REQ/HOLD sequencer.
//
// Ports
//   CB              core clock, rising edge
//   resetCore_N     asynchronous active-low reset
//   tbTapWd[3:0]    time-base taps for the watchdog period
//   tbTapFit[3:0]   time-base taps for the FIT period
//   tcrWp[1:0]      watchdog tap select
//   tcrFp[1:0]      FIT tap select
//   tcrWrc[1:0]     watchdog reset type (00 none, 01 core, 10 chip, 11 system)
//   tcrWrite        TCR written this cycle; suppresses edge detection
//   timerFreeze     debug freeze; holds taps and suppresses events
//   tsrEnw, tsrWis  current TSR watchdog enable / interrupt status
//   resetAck        reset logic has taken the request
//   wdPulse         one-cycle watchdog period event
//   hwSetFitStatus  one-cycle FIT event
//   hwSetWdIntrp    one-cycle watchdog interrupt status set
//   hwSetWdRst      one-cycle watchdog reset status set
//   wdRstType[1:0]  reset type latched at the last reset request
//   wdResetReq      level reset request, high while in REQ
module p405s_wd_timer_event (
    input  logic       CB,
    input  logic       resetCore_N,
    input  logic [3:0] tbTapWd,
    input  logic [3:0] tbTapFit,
    input  logic [1:0] tcrWp,
    input  logic [1:0] tcrFp,
    input  logic [1:0] tcrWrc,
    input  logic       tcrWrite,
    input  logic       timerFreeze,
    input  logic       tsrEnw,
    input  logic       tsrWis,
    input  logic       resetAck,
    output logic       wdPulse,
    output logic       hwSetFitStatus,
    output logic       hwSetWdIntrp,
    output logic       hwSetWdRst,
    output logic [1:0] wdRstType,
    output logic       wdResetReq
);

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned HOLD_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic             wd_tap;
    logic             fit_tap;

    logic wd_sel_c;
    logic fit_sel_c;
    logic eval_c;
    logic wd_edge_c;
    logic fit_edge_c;
    logic rst_hit_c;

    // Selected taps and edge qualification; a TCR write or freeze masks edges
    assign wd_sel_c   = tbTapWd[tcrWp];
    assign fit_sel_c  = tbTapFit[tcrFp];
    assign eval_c     = ~tcrWrite & ~timerFreeze;
    assign wd_edge_c  = eval_c & wd_sel_c & ~wd_tap;
    assign fit_edge_c = eval_c & fit_sel_c & ~fit_tap;

    // Reset request only when enabled, already interrupted, a type is set,
    // and no earlier request is still being serviced
    assign rst_hit_c  = wd_edge_c & tsrEnw & tsrWis & (tcrWrc != 2'b00) & (state == IDLE);

    // Tap history, event pulses and reset-request sequencer
    always_ff @(posedge CB or negedge resetCore_N) begin
        if (!resetCore_N) begin
            state          <= IDLE;
            hold_cnt       <= '0;
            wd_tap         <= 1'b0;
            fit_tap        <= 1'b0;
            wdPulse        <= 1'b0;
            hwSetFitStatus <= 1'b0;
            hwSetWdIntrp   <= 1'b0;
            hwSetWdRst     <= 1'b0;
            wdRstType      <= 2'b00;
            wdResetReq     <= 1'b0;
        end else begin
            // Freeze holds the history so the first edge after release is
            // judged against the pre-freeze value; a TCR write just reloads
            if (!timerFreeze) begin
                wd_tap  <= wd_sel_c;
                fit_tap <= fit_sel_c;
            end

            wdPulse        <= wd_edge_c;
            hwSetFitStatus <= fit_edge_c;
            hwSetWdIntrp   <= wd_edge_c & tsrEnw & ~tsrWis;
            hwSetWdRst     <= rst_hit_c;

            case (state)
                IDLE: begin
                    if (rst_hit_c) begin
                        state      <= REQ;
                        wdRstType  <= tcrWrc;
                        wdResetReq <= 1'b1;
                    end
                end
                REQ: begin
                    if (resetAck) begin
                        state      <= HOLD;
                        hold_cnt   <= CNT_W'(HOLD_CYCLES - 1);
                        wdResetReq <= 1'b0;
                    end
                end
                HOLD: begin
                    // Counts 15..0, so HOLD lasts exactly 16 cycles
                    if (hold_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    wdResetReq <= 1'b0;
                end
            endcase
        end
    end

endmodule
